dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to ack; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256: storage size in 32-bit words, a power of two.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_i  input  1  access request from the pipeline MEM stage; held stable by the requester while stall_o=1.
REQ-006 SHALL have port we_i  input  1  1=store, 0=load; sampled with req_i.
REQ-007 SHALL have port addr_i  input  32  byte address of the access.
REQ-008 SHALL have port wdata_i  input  32  store data.
REQ-009 SHALL have port stall_o  output  1  freezes PC and the pipeline registers while an access is outstanding.
REQ-010 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata_o  output  32  load data; valid while ack_o=1 and held until the next completion.
REQ-012 SHALL have port err_o  output  1  misaligned-access flag (see Configuration).

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and RESP, plus a down-counter of 4 bits.
REQ-014 IDLE with req_i=1 SHALL latch we_i, addr_i and wdata_i, load the counter with LATENCY-2, and go to BUSY; for LATENCY=1 it SHALL go directly to RESP.
REQ-015 BUSY SHALL decrement the counter every cycle and go to RESP on the edge where the counter equals 0.
REQ-016 On the edge entering RESP, the access SHALL execute: a store writes the storage, and a load registers the word into rdata_o.
REQ-017 RESP SHALL assert ack_o for exactly one cycle and return to IDLE unconditionally.
REQ-018 stall_o SHALL be combinational: (IDLE and req_i) or BUSY; it SHALL be 0 in RESP.
REQ-019 A request accepted at cycle 0 SHALL produce ack_o at cycle LATENCY, with stall_o high for cycles 0..LATENCY-1.
REQ-020 req_i SHALL be ignored in BUSY and RESP; back-to-back accesses are accepted in the IDLE cycle following RESP.
REQ-021 Word index SHALL be addr_i[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4 bytes.
REQ-022 A store SHALL leave rdata_o unchanged.
REQ-023 Input changes while not in IDLE SHALL NOT affect the latched access.

Reset
REQ-024 rst_i=1 SHALL force IDLE, counter=0, rdata_o=0, ack_o=0 and err_o=0 on the next edge; stall_o follows REQ-018.
REQ-025 Reset during BUSY SHALL discard the pending access: no write occurs and no ack_o is issued.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro DMEM_MISALIGN_CHECK_EN defined: a latched addr[1:0]!=0 SHALL suppress the store, return rdata_o=0, and pulse err_o together with ack_o; timing is unchanged.
REQ-028 Macro DMEM_MISALIGN_CHECK_EN undefined: err_o SHALL be tied to 0 and addr_i[1:0] SHALL be ignored.

Verification (LATENCY=4, DEPTH_WORDS=256 unless noted)
REQ-029 Store 0xDEADBEEF to 0x10 at cycle 0, then load 0x10 -> stall_o high for cycles 0-3, ack_o at cycle 4; the load's ack arrives 4 cycles after it is accepted in IDLE, with rdata_o=0xDEADBEEF.
REQ-030 Load from 0x400 after a store of 0x12345678 to 0x0 -> rdata_o=0x12345678 (wrap-around).
REQ-031 LATENCY=1 -> store then load to 0x8 -> each access gets ack_o one cycle after acceptance, with stall_o high for exactly one cycle.
REQ-032 Assert rst_i at cycle 2 of a store of 0xAAAA5555 to 0x20, then load 0x20 -> no ack_o for the aborted store; the load returns the prior contents.
REQ-033 Toggle addr_i and wdata_i during BUSY -> the originally latched address and data are used.
REQ-034 DMEM_MISALIGN_CHECK_EN defined: store 0x1 to 0x22 -> err_o=1 with ack_o at cycle 4; a subsequent load of 0x20 returns the unchanged word.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Fixed-latency data-memory responder for a pipelined core. A request seen
//   in IDLE is latched, the pipeline is stalled while the access is in
//   flight, and the access executes on the edge that enters RESP. ack_o then
//   pulses for one cycle.
//
//   Optional feature (compile-time macro DMEM_MISALIGN_CHECK_EN):
//     defined   - a latched address with addr[1:0] != 0 suppresses the store,
//                 returns rdata_o = 0 and pulses err_o with ack_o.
//     undefined - err_o is tied to 0 and addr_i[1:0] is ignored.
//
//   Parameters
//     LATENCY      cycles from acceptance to ack_o (1..15)
//     DEPTH_WORDS  storage size in 32-bit words (power of two, >= 2)
//
//   Ports
//     clk_i    in   sole clock, rising edge
//     rst_i    in   synchronous active-high reset
//     req_i    in   access request (held stable by requester while stalled)
//     we_i     in   1 = store, 0 = load
//     addr_i   in   byte address; word index = addr_i[log2(DEPTH_WORDS)+1:2]
//     wdata_i  in   store data
//     stall_o  out  (IDLE and req_i) or BUSY
//     ack_o    out  one-cycle completion pulse (RESP)
//     rdata_o  out  load data, held until the next load completion
//     err_o    out  misaligned-access flag, coincident with ack_o
//
//   state | meaning
//   IDLE  | waiting for req_i; accepts and latches the access
//   BUSY  | counting down the remaining latency
//   RESP  | access has executed; ack_o high for one cycle
module dmem_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // BUSY exits on the edge where the counter is 0, so LATENCY-2 gives
  // acceptance edge + (LATENCY-1) BUSY cycles = ack in cycle LATENCY.
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [AW+1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              go_resp;
  logic              exec_we;
  logic [AW+1:0]     exec_addr;
  logic [31:0]       exec_wdata;
  logic [AW-1:0]     exec_idx;
  logic              misaligned;
  logic              unused_bits;

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    accept  = 1'b0;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = req_i;
        if (req_i) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // With LATENCY=1 the access executes on the acceptance edge itself, so the
  // live inputs are used in IDLE; otherwise the latched copy is used.
  assign exec_we    = (state_q == IDLE) ? we_i            : we_q;
  assign exec_addr  = (state_q == IDLE) ? addr_i[AW+1:0]  : addr_q;
  assign exec_wdata = (state_q == IDLE) ? wdata_i         : wdata_q;
  assign exec_idx   = exec_addr[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  logic err_q;
  assign misaligned = (exec_addr[1:0] != 2'b00);
  assign err_o      = ack_o & err_q;
`else
  assign misaligned = 1'b0;
  assign err_o      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i[AW+1:0];
        wdata_q <= wdata_i;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (go_resp) begin
        if (!exec_we) rdata_q <= misaligned ? 32'd0 : mem[exec_idx];
`ifdef DMEM_MISALIGN_CHECK_EN
        err_q <= misaligned;
`endif
      end
    end
  end

  // Storage is never reset; a reset edge cancels any write on that edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && go_resp && exec_we && !misaligned) mem[exec_idx] <= exec_wdata;
  end

  assign ack_o   = (state_q == RESP);
  assign rdata_o = rdata_q;

  assign unused_bits = ^{addr_i[31:AW+2], addr_q[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, req4, we4, stall4, ack4, err4;
  logic [31:0] addr4, wdata4, rdata4;
  logic        rst1, req1, we1, stall1, ack1, err1;
  logic [31:0] addr1, wdata1, rdata1;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.LATENCY(4), .DEPTH_WORDS(256)) u_lat4 (
    .clk_i(clk), .rst_i(rst4), .req_i(req4), .we_i(we4), .addr_i(addr4),
    .wdata_i(wdata4), .stall_o(stall4), .ack_o(ack4), .rdata_o(rdata4), .err_o(err4)
  );

  dmem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) u_lat1 (
    .clk_i(clk), .rst_i(rst1), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .stall_o(stall1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1)
  );

  task automatic drive(input bit sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin req1 = req; we1 = we; addr1 = addr; wdata1 = wdata; end
    else     begin req4 = req; we4 = we; addr4 = addr; wdata4 = wdata; end
  endtask

  // One access over a fixed 12-cycle window; cycle 0 is the acceptance cycle.
  task automatic do_acc(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit toggle,
                        output int ack_cyc, output int stall_cnt, output int ack_cnt,
                        output logic [31:0] rd, output logic er, output logic [31:0] rd_after);
    ack_cyc = -1; stall_cnt = 0; ack_cnt = 0; rd = 32'd0; er = 1'b0;
    drive(sel, 1'b1, we, addr, wdata);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (sel ? stall1 : stall4) stall_cnt++;
      if (sel ? ack1 : ack4) begin
        ack_cnt++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          rd = sel ? rdata1 : rdata4;
          er = sel ? err1 : err4;
        end
      end
      @(posedge clk); #1;
      if (toggle && (c % 2 == 0)) drive(sel, 1'b0, we, ~addr, ~wdata);
      else                        drive(sel, 1'b0, we, addr, wdata);
    end
    rd_after = sel ? rdata1 : rdata4;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 req4 = 1'b1;
    @(negedge clk);
    checks++; if (stall4 !== 1'b1) begin errors++; $display("FAIL rst_stall_req: got %b want 1", stall4); end
    checks++; if (ack4 !== 1'b0) begin errors++; $display("FAIL rst_ack4: got %b want 0", ack4); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL rst_err4: got %b want 0", err4); end
    checks++; if (rdata4 !== 32'd0) begin errors++; $display("FAIL rst_rdata4: got %h want 0", rdata4); end
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL rst_stall1: got %b want 0", stall1); end
    checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL rst_rdata1: got %h want 0", rdata1); end
    @(posedge clk); #1;
    req4 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    checks++; if (ack4 !== 1'b0 || stall4 !== 1'b0) begin errors++; $display("FAIL rst_no_accept: got ack=%b stall=%b want 0 0", ack4, stall4); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int ac, sc, an; logic [31:0] rd, ra; logic er;
    do_acc(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, ac, sc, an, rd, er, ra);
    checks++; if (ac !== 4) begin errors++; $display("FAIL st_ack_cycle: got %0d want 4", ac); end
    checks++; if (sc !== 4) begin errors++; $display("FAIL st_stall_cycles: got %0d want 4", sc); end
    checks++; if (an !== 1) begin errors++; $display("FAIL st_ack_len: got %0d want 1", an); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL st_rdata_unchanged: got %h want 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL st_err: got %b want 0", er); end
    do_acc(0, 1'b0, 32'h10, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (ac !== 4) begin errors++; $display("FAIL ld_ack_cycle: got %0d want 4", ac); end
    checks++; if (sc !== 4) begin errors++; $display("FAIL ld_stall_cycles: got %0d want 4", sc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata: got %h want deadbeef", rd); end
    checks++; if (ra !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata_held: got %h want deadbeef", ra); end
  endtask

  task automatic test_wrap();
    int ac, sc, an; logic [31:0] rd, ra; logic er;
    do_acc(0, 1'b1, 32'h0, 32'h12345678, 0, ac, sc, an, rd, er, ra);
    do_acc(0, 1'b0, 32'h400, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap_400: got %h want 12345678", rd); end
    do_acc(0, 1'b0, 32'hFFFFFC00, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap_high: got %h want 12345678", rd); end
  endtask

  task automatic test_toggle();
    int ac, sc, an; logic [31:0] rd, ra; logic er;
    do_acc(0, 1'b1, 32'h30, 32'hCAFEF00D, 1, ac, sc, an, rd, er, ra);
    checks++; if (ac !== 4) begin errors++; $display("FAIL tog_st_ack_cycle: got %0d want 4", ac); end
    do_acc(0, 1'b0, 32'h30, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL tog_store_data: got %h want cafef00d", rd); end
    do_acc(0, 1'b0, 32'h10, 32'h0, 1, ac, sc, an, rd, er, ra);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL tog_load_addr: got %h want deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    int ack_at[$];
    logic [31:0] rds[$];
    int stall_lo = 0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (!stall4) stall_lo++;
      if (ack4) begin ack_at.push_back(c); rds.push_back(rdata4); end
      if (c == 4) addr4 = 32'h0;
      if (c == 9) req4 = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (ack_at.size() !== 2) begin errors++; $display("FAIL b2b_ack_count: got %0d want 2", ack_at.size()); end
    checks++; if ((ack_at.size() > 0 ? ack_at[0] : -1) !== 4) begin errors++; $display("FAIL b2b_first_ack: got %0d want 4", ack_at.size() > 0 ? ack_at[0] : -1); end
    checks++; if ((ack_at.size() > 1 ? ack_at[1] : -1) !== 9) begin errors++; $display("FAIL b2b_second_ack: got %0d want 9", ack_at.size() > 1 ? ack_at[1] : -1); end
    checks++; if ((rds.size() > 0 ? rds[0] : 32'hX) !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata0: got %h want deadbeef", rds.size() > 0 ? rds[0] : 32'hX); end
    checks++; if ((rds.size() > 1 ? rds[1] : 32'hX) !== 32'h12345678) begin errors++; $display("FAIL b2b_rdata1: got %h want 12345678", rds.size() > 1 ? rds[1] : 32'hX); end
    checks++; if (stall_lo !== 6) begin errors++; $display("FAIL b2b_stall_low_cycles: got %0d want 6", stall_lo); end
  endtask

  task automatic test_reset_abort();
    int ac, sc, an; logic [31:0] rd, ra; logic er;
    int acks = 0, stalls = 0;
    do_acc(0, 1'b1, 32'h20, 32'h11111111, 0, ac, sc, an, rd, er, ra);
    do_acc(0, 1'b0, 32'h20, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL abort_prior: got %h want 11111111", rd); end
    drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAA5555);
    @(posedge clk); #1 req4 = 1'b0;
    @(posedge clk); #1 rst4 = 1'b1;
    @(posedge clk); #1 rst4 = 1'b0;
    @(negedge clk);
    checks++; if (rdata4 !== 32'd0) begin errors++; $display("FAIL abort_rdata_reset: got %h want 0", rdata4); end
    for (int c = 0; c < 8; c++) begin
      if (ack4) acks++;
      if (stall4) stalls++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    checks++; if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL abort_no_stall: got %0d want 0", stalls); end
    do_acc(0, 1'b0, 32'h20, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (ac !== 4) begin errors++; $display("FAIL abort_ld_ack_cycle: got %0d want 4", ac); end
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL abort_no_write: got %h want 11111111", rd); end
  endtask

  task automatic test_misalign();
    int ac, sc, an; logic [31:0] rd, ra; logic er;
    do_acc(0, 1'b1, 32'h22, 32'h1, 0, ac, sc, an, rd, er, ra);
    checks++; if (ac !== 4) begin errors++; $display("FAIL mis_st_ack_cycle: got %0d want 4", ac); end
`ifdef DMEM_MISALIGN_CHECK_EN
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_st_err: got %b want 1", er); end
    do_acc(0, 1'b0, 32'h20, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL mis_word_kept: got %h want 11111111", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_aligned_err: got %b want 0", er); end
    do_acc(0, 1'b0, 32'h12, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL mis_ld_rdata: got %h want 0", rd); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_ld_err: got %b want 1", er); end
`else
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_st_err: got %b want 0", er); end
    do_acc(0, 1'b0, 32'h20, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (rd !== 32'h00000001) begin errors++; $display("FAIL mis_low_bits_ignored: got %h want 00000001", rd); end
    do_acc(0, 1'b0, 32'h13, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_ld_low_bits: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_ld_err: got %b want 0", er); end
`endif
  endtask

  task automatic test_latency1();
    int ac, sc, an; logic [31:0] rd, ra; logic er;
    do_acc(1, 1'b1, 32'h8, 32'h5A5A5A5A, 0, ac, sc, an, rd, er, ra);
    checks++; if (ac !== 1) begin errors++; $display("FAIL l1_st_ack_cycle: got %0d want 1", ac); end
    checks++; if (sc !== 1) begin errors++; $display("FAIL l1_st_stall_cycles: got %0d want 1", sc); end
    checks++; if (an !== 1) begin errors++; $display("FAIL l1_st_ack_len: got %0d want 1", an); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL l1_st_rdata_unchanged: got %h want 0", rd); end
    do_acc(1, 1'b0, 32'h8, 32'h0, 0, ac, sc, an, rd, er, ra);
    checks++; if (ac !== 1) begin errors++; $display("FAIL l1_ld_ack_cycle: got %0d want 1", ac); end
    checks++; if (sc !== 1) begin errors++; $display("FAIL l1_ld_stall_cycles: got %0d want 1", sc); end
    checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL l1_ld_rdata: got %h want 5a5a5a5a", rd); end
    do_acc(1, 1'b0, 32'h408, 32'h0, 1, ac, sc, an, rd, er, ra);
    checks++; if (ra !== 32'h5A5A5A5A) begin errors++; $display("FAIL l1_wrap_held: got %h want 5a5a5a5a", ra); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_toggle();
    test_back_to_back();
    test_reset_abort();
    test_misalign();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
